zebra_crossing_controller: RTL

- Frame-level decision controller downstream of the zebra crossing detector.
- Consumes one per-frame result (detection_valid, zebra_detected, blob_count) and debounces it across frames with an N-of-N confirm / M-miss release state machine.
- Issues a stop request to the motion controller over a req/ack handshake and runs a post-crossing cooldown.
- Runs a frame watchdog that flags a stalled video pipeline.

---
 rtl/zebra_crossing_controller_if.sv | 28 ++
 rtl/zebra_crossing_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/zebra_crossing_controller_if.sv
// Frame-result, stop-handshake and status bundle between the detector pipeline,
// the motion controller and the zebra crossing decision controller.
interface zebra_crossing_controller_if;
  logic        enable;
  logic        detection_valid;
  logic        zebra_detected;
  logic [7:0]  blob_count;
  logic        stop_ack;
  logic        stop_req;
  logic        crossing_active;
  logic [2:0]  state;
  logic [7:0]  hit_count;
  logic [7:0]  last_blob_count;
  logic [15:0] frames_seen;
  logic        frame_timeout;

  modport master (
    output enable, detection_valid, zebra_detected, blob_count, stop_ack,
    input  stop_req, crossing_active, state, hit_count, last_blob_count,
           frames_seen, frame_timeout
  );

  modport slave (
    input  enable, detection_valid, zebra_detected, blob_count, stop_ack,
    output stop_req, crossing_active, state, hit_count, last_blob_count,
           frames_seen, frame_timeout
  );
endinterface

// File: rtl/zebra_crossing_controller.sv
// Debounces per-frame zebra detections into a crossing decision, drives the
// stop req/ack handshake, runs a post-crossing cooldown and a frame watchdog.
module zebra_crossing_controller #(
  parameter int CONFIRM_FRAMES  = 3,
  parameter int RELEASE_FRAMES  = 5,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  zebra_crossing_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_SEARCH   = 3'd1,
    ST_CONFIRM  = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      CONFIRM_N  = 8'(CONFIRM_FRAMES);
  localparam logic [7:0]      RELEASE_N  = 8'(RELEASE_FRAMES);
  localparam logic [7:0]      COOLDOWN_N = 8'(COOLDOWN_FRAMES);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE     = WD_W'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_hit;
  logic [7:0]      w_hit_nxt;
  logic [7:0]      r_miss;
  logic [7:0]      w_miss_nxt;
  logic [7:0]      r_cool;
  logic [7:0]      w_cool_nxt;
  logic [WD_W-1:0] r_wd;
  logic [WD_W-1:0] w_wd_nxt;
  logic            r_stop_req;
  logic            w_stop_req_nxt;
  logic            r_active;
  logic            w_active_nxt;
  logic            r_timeout;
  logic            w_timeout_nxt;
  logic [7:0]      r_last_blob;
  logic [7:0]      w_last_blob_nxt;
  logic [15:0]     r_frames;
  logic [15:0]     w_frames_nxt;

  logic w_pos;
  logic w_neg;
  logic w_wd_expire;
  logic w_enter_active;

  assign w_pos = bus.detection_valid & bus.zebra_detected;
  assign w_neg = bus.detection_valid & ~bus.zebra_detected;
  // A frame arriving on the expiry cycle wins over the watchdog.
  assign w_wd_expire = bus.enable & ~bus.detection_valid & (r_wd == WD_LAST);
  assign w_enter_active = (w_state_nxt == ST_ACTIVE) && (r_state != ST_ACTIVE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_DISABLED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and debounce counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = r_hit;
    w_miss_nxt  = r_miss;
    w_cool_nxt  = r_cool;
    if (!bus.enable) begin
      w_state_nxt = ST_DISABLED;
      w_hit_nxt   = 8'd0;
      w_miss_nxt  = 8'd0;
      w_cool_nxt  = 8'd0;
    end else begin
      case (r_state)
        ST_DISABLED: begin
          w_state_nxt = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (w_pos) begin
            w_hit_nxt   = 8'd1;
            w_miss_nxt  = 8'd0;
            w_state_nxt = (CONFIRM_N == 8'd1) ? ST_ACTIVE : ST_CONFIRM;
          end else begin
            w_hit_nxt   = 8'd0;
            w_state_nxt = ST_SEARCH;
          end
        end
        ST_CONFIRM: begin
          if (w_pos) begin
            w_hit_nxt = r_hit + 8'd1;
            if ((r_hit + 8'd1) == CONFIRM_N) begin
              w_state_nxt = ST_ACTIVE;
              w_miss_nxt  = 8'd0;
            end else begin
              w_state_nxt = ST_CONFIRM;
            end
          end else if (w_neg || w_wd_expire) begin
            w_state_nxt = ST_SEARCH;
            w_hit_nxt   = 8'd0;
          end else begin
            w_state_nxt = ST_CONFIRM;
          end
        end
        ST_ACTIVE: begin
          // Watchdog expiry deliberately leaves the vehicle stopped here.
          if (w_pos) begin
            w_miss_nxt = 8'd0;
            w_hit_nxt  = (r_hit == 8'hFF) ? 8'hFF : (r_hit + 8'd1);
          end else if (w_neg) begin
            if ((r_miss + 8'd1) == RELEASE_N) begin
              w_state_nxt = ST_COOLDOWN;
              w_hit_nxt   = 8'd0;
              w_miss_nxt  = 8'd0;
              w_cool_nxt  = 8'd0;
            end else begin
              w_miss_nxt = r_miss + 8'd1;
            end
          end else begin
            w_miss_nxt = r_miss;
          end
        end
        ST_COOLDOWN: begin
          if (bus.detection_valid) begin
            if ((r_cool + 8'd1) == COOLDOWN_N) begin
              w_state_nxt = ST_SEARCH;
              w_cool_nxt  = 8'd0;
            end else begin
              w_cool_nxt = r_cool + 8'd1;
            end
          end else begin
            w_cool_nxt = r_cool;
          end
        end
        default: begin
          w_state_nxt = ST_DISABLED;
          w_hit_nxt   = 8'd0;
          w_miss_nxt  = 8'd0;
          w_cool_nxt  = 8'd0;
        end
      endcase
    end
  end

  // Next values of the handshake, watchdog and frame-latch outputs.
  always_comb begin
    w_active_nxt    = (w_state_nxt == ST_ACTIVE);
    w_stop_req_nxt  = r_stop_req;
    w_timeout_nxt   = r_timeout;
    w_wd_nxt        = r_wd;
    w_last_blob_nxt = r_last_blob;
    w_frames_nxt    = r_frames;
    if (!bus.enable) begin
      w_stop_req_nxt = 1'b0;
      w_timeout_nxt  = 1'b0;
      w_wd_nxt       = '0;
      w_frames_nxt   = 16'd0;
    end else begin
      if (w_enter_active) begin
        w_stop_req_nxt = 1'b1;
      end else if (r_stop_req && bus.stop_ack) begin
        w_stop_req_nxt = 1'b0;
      end else begin
        w_stop_req_nxt = r_stop_req;
      end
      if (bus.detection_valid) begin
        w_wd_nxt        = '0;
        w_last_blob_nxt = bus.blob_count;
        w_frames_nxt    = (r_frames == 16'hFFFF) ? 16'hFFFF : (r_frames + 16'd1);
      end else if (w_wd_expire) begin
        w_wd_nxt      = '0;
        w_timeout_nxt = 1'b1;
      end else begin
        w_wd_nxt = r_wd + WD_ONE;
      end
    end
  end

  // Counter and registered-output storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit       <= 8'd0;
      r_miss      <= 8'd0;
      r_cool      <= 8'd0;
      r_wd        <= '0;
      r_stop_req  <= 1'b0;
      r_active    <= 1'b0;
      r_timeout   <= 1'b0;
      r_last_blob <= 8'd0;
      r_frames    <= 16'd0;
    end else begin
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_cool      <= w_cool_nxt;
      r_wd        <= w_wd_nxt;
      r_stop_req  <= w_stop_req_nxt;
      r_active    <= w_active_nxt;
      r_timeout   <= w_timeout_nxt;
      r_last_blob <= w_last_blob_nxt;
      r_frames    <= w_frames_nxt;
    end
  end

  assign bus.stop_req        = r_stop_req;
  assign bus.crossing_active = r_active;
  assign bus.state           = r_state;
  assign bus.hit_count       = r_hit;
  assign bus.last_blob_count = r_last_blob;
  assign bus.frames_seen     = r_frames;
  assign bus.frame_timeout   = r_timeout;

endmodule
